// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU operation classes, R-type funct
// codes and the multiply sequencing states.
package ex_pkg;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_MULT = 6'h18;

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} ex_state_e;
endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: low 32 bits of an unsigned 32x32 product,
// one multiplier bit consumed per clock after i_start.
module ex_mul_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_done,
  output logic [31:0] o_product
);
  logic [31:0] r_a, r_b, r_acc;
  logic [4:0]  r_cnt;
  logic        r_run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_b[0]) r_acc <= r_acc + r_a;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) r_run <= 1'b0;
    end
  end

  // High during the cycle whose closing edge performs the 32nd iteration
  assign o_done    = r_run && (r_cnt == 5'd31);
  assign o_product = r_acc;
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target, destination select, multiply sequencing
// and the EX/MEM pipeline register.
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_RegWrite,
  input  logic        wb_MemToReg,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic        ex_RegDst,
  input  logic        ex_AluSrc,
  input  logic        ex_branch,
  input  logic [1:0]  ex_AluOp,
  input  logic [31:0] pc4,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [15:0] immediate,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic        wb_RegWrite_out,
  output logic        wb_MemToReg_out,
  output logic        mem_MemRead_out,
  output logic        mem_MemWrite_out,
  output logic        mem_branch_out,
  output logic [31:0] branch_target_out,
  output logic        zero_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] write_data_out,
  output logic [4:0]  dest_reg_out,
  output logic        ex_busy
);
  ex_state_e   r_state, w_next;
  logic [31:0] w_imm_sext, w_opb, w_alu, w_result, w_product;
  logic [5:0]  w_funct;
  logic        w_is_mul, w_busy, w_start, w_load, w_mul_done;

  assign w_imm_sext = {{16{immediate[15]}}, immediate};
  assign w_opb      = ex_AluSrc ? w_imm_sext : read_data2;
  assign w_funct    = immediate[5:0];
  assign w_is_mul   = (ex_AluOp == ALUOP_FUNCT) && (w_funct == FN_MULT);

  always_comb begin
    w_alu = '0;
    case (ex_AluOp)
      ALUOP_ADD, ALUOP_ADDI: w_alu = read_data1 + w_opb;
      ALUOP_SUB:             w_alu = read_data1 - w_opb;
      default: begin
        case (w_funct)
          FN_ADD:  w_alu = read_data1 + w_opb;
          FN_SUB:  w_alu = read_data1 - w_opb;
          FN_AND:  w_alu = read_data1 & w_opb;
          FN_OR:   w_alu = read_data1 | w_opb;
          FN_SLT:  w_alu = {31'd0, $signed(read_data1) < $signed(w_opb)};
          default: w_alu = '0;
        endcase
      end
    endcase
  end

  ex_mul_iter u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_a       (read_data1),
    .i_b       (w_opb),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_is_mul) w_next = MUL_RUN;
      MUL_RUN:  if (w_mul_done) w_next = MUL_DONE;
      MUL_DONE: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy  = 1'b0;
    w_start = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_is_mul) begin
          w_busy  = 1'b1;
          w_start = 1'b1;
        end else begin
          w_load = 1'b1;
        end
      end
      MUL_RUN:  w_busy = 1'b1;
      MUL_DONE: w_load = 1'b1;
      default:  w_load = 1'b0;
    endcase
  end

  // Upstream may still present a mult while reset is held; keep the stall low
  assign ex_busy  = w_busy & ~reset;
  assign w_result = (r_state == MUL_DONE) ? w_product : w_alu;

  // EX/MEM register; non-load cycles insert a bubble (controls cleared, data held)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_RegWrite_out   <= 1'b0;
      wb_MemToReg_out   <= 1'b0;
      mem_MemRead_out   <= 1'b0;
      mem_MemWrite_out  <= 1'b0;
      mem_branch_out    <= 1'b0;
      branch_target_out <= '0;
      zero_out          <= 1'b0;
      alu_result_out    <= '0;
      write_data_out    <= '0;
      dest_reg_out      <= '0;
    end else if (w_load) begin
      wb_RegWrite_out   <= wb_RegWrite;
      wb_MemToReg_out   <= wb_MemToReg;
      mem_MemRead_out   <= mem_MemRead;
      mem_MemWrite_out  <= mem_MemWrite;
      mem_branch_out    <= ex_branch;
      branch_target_out <= pc4 + {w_imm_sext[29:0], 2'b00};
      zero_out          <= (w_result == 32'd0);
      alu_result_out    <= w_result;
      write_data_out    <= read_data2;
      dest_reg_out      <= ex_RegDst ? rd : rt;
    end else begin
      wb_RegWrite_out   <= 1'b0;
      wb_MemToReg_out   <= 1'b0;
      mem_MemRead_out   <= 1'b0;
      mem_MemWrite_out  <= 1'b0;
      mem_branch_out    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        wb_RegWrite, wb_MemToReg, mem_MemRead, mem_MemWrite;
  logic        ex_RegDst, ex_AluSrc, ex_branch;
  logic [1:0]  ex_AluOp;
  logic [31:0] pc4, read_data1, read_data2;
  logic [15:0] immediate;
  logic [4:0]  rt, rd;
  logic        wb_RegWrite_out, wb_MemToReg_out, mem_MemRead_out, mem_MemWrite_out, mem_branch_out;
  logic [31:0] branch_target_out, alu_result_out, write_data_out;
  logic        zero_out, ex_busy;
  logic [4:0]  dest_reg_out;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .ex_RegDst(ex_RegDst), .ex_AluSrc(ex_AluSrc), .ex_branch(ex_branch),
    .ex_AluOp(ex_AluOp), .pc4(pc4), .read_data1(read_data1), .read_data2(read_data2),
    .immediate(immediate), .rt(rt), .rd(rd),
    .wb_RegWrite_out(wb_RegWrite_out), .wb_MemToReg_out(wb_MemToReg_out),
    .mem_MemRead_out(mem_MemRead_out), .mem_MemWrite_out(mem_MemWrite_out),
    .mem_branch_out(mem_branch_out), .branch_target_out(branch_target_out),
    .zero_out(zero_out), .alu_result_out(alu_result_out),
    .write_data_out(write_data_out), .dest_reg_out(dest_reg_out), .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act(input int k);
    case (k)
      0:       return {31'd0, ex_busy};
      1:       return {27'd0, wb_RegWrite_out, wb_MemToReg_out, mem_MemRead_out,
                       mem_MemWrite_out, mem_branch_out};
      2:       return alu_result_out;
      3:       return {31'd0, zero_out};
      4:       return {27'd0, dest_reg_out};
      5:       return branch_target_out;
      default: return write_data_out;
    endcase
  endfunction

  exp_t e;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (act(e.kind) !== e.val) begin
        n_bad++;
        $display("FAIL %s cyc=%0d field=%0d got=%h want=%h", e.name, cyc, e.kind, act(e.kind), e.val);
      end
    end
  end

  task automatic chk(input int c, input int k, input logic [31:0] v, input string nm);
    exp_t x;
    x.cyc = c; x.kind = k; x.val = v; x.name = nm;
    q.push_back(x);
  endtask

  task automatic expout(input int c, input logic [4:0] ctl, input logic [31:0] alu, input logic z,
                        input logic [4:0] dst, input logic [31:0] bt, input logic [31:0] wd,
                        input string nm);
    chk(c, 1, {27'd0, ctl}, nm);
    chk(c, 2, alu, nm);
    chk(c, 3, {31'd0, z}, nm);
    chk(c, 4, {27'd0, dst}, nm);
    chk(c, 5, bt, nm);
    chk(c, 6, wd, nm);
  endtask

  // ctl order: RegWrite, MemToReg, MemRead, MemWrite, branch
  task automatic setin(input logic [4:0] c, input logic rdst, input logic asrc, input logic [1:0] op,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] im, input logic [4:0] t, input logic [4:0] d);
    {wb_RegWrite, wb_MemToReg, mem_MemRead, mem_MemWrite, ex_branch} = c;
    ex_RegDst = rdst; ex_AluSrc = asrc; ex_AluOp = op;
    pc4 = pc; read_data1 = a; read_data2 = b; immediate = im; rt = t; rd = d;
  endtask

  task automatic op1(input string nm, input logic [4:0] c, input logic rdst, input logic asrc,
                     input logic [1:0] op, input logic [31:0] pc, input logic [31:0] a,
                     input logic [31:0] b, input logic [15:0] im, input logic [4:0] t,
                     input logic [4:0] d, input logic [31:0] e_alu, input logic e_z,
                     input logic [4:0] e_dst, input logic [31:0] e_bt);
    setin(c, rdst, asrc, op, pc, a, b, im, t, d);
    chk(cyc, 0, 32'd0, {nm, "_busy"});
    expout(cyc + 1, c, e_alu, e_z, e_dst, e_bt, b, nm);
    @(posedge clk); #1;
  endtask

  task automatic mul(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    int k;
    k = cyc;
    setin(5'b10000, 1'b1, 1'b0, 2'b10, 32'h200, a, b, 16'h0018, 5'd4, 5'd5);
    for (int c = k; c <= k + 34; c++) begin
      if (c <= k + 32) chk(c, 0, 32'd1, {nm, "_busy"});
      if (c == k + 33) chk(c, 0, 32'd0, {nm, "_busy_done"});
      if (c > k && c <= k + 33) chk(c, 1, 32'd0, {nm, "_bubble"});
      if (c == k + 34) expout(c, 5'b10000, p, p == 32'd0, 5'd5, 32'h260, b, nm);
    end
    repeat (34) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    reset = 1'b1;
    setin(5'b00000, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 16'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk(cyc, 0, 32'd0, "reset_busy");
    expout(cyc, 5'b00000, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, "reset_out");
    @(posedge clk); #1;
    reset = 1'b0;

    op1("add_rr",  5'b10000, 1, 0, 2'b10, 32'h0, 32'd5, 32'd7, 16'h0020, 5'd9, 5'd3, 32'd12, 0, 5'd3, 32'h80);
    op1("beq",     5'b00001, 0, 0, 2'b01, 32'h100, 32'h1234, 32'h1234, 16'hFFFF, 5'd31, 5'd2, 32'd0, 1, 5'd31, 32'hFC);
    op1("slt_neg", 5'b10000, 1, 0, 2'b10, 32'h40, 32'hFFFFFFFF, 32'd1, 16'h002A, 5'd1, 5'd8, 32'd1, 0, 5'd8, 32'hE8);
    op1("slt_pos", 5'b10000, 1, 0, 2'b10, 32'h40, 32'd1, 32'hFFFFFFFF, 16'h002A, 5'd1, 5'd8, 32'd0, 1, 5'd8, 32'hE8);
    op1("lw_imm",  5'b11100, 0, 1, 2'b00, 32'h10, 32'h10, 32'hDEAD, 16'hFFF0, 5'd7, 5'd9, 32'd0, 1, 5'd7, 32'hFFFFFFD0);
    op1("sw_imm",  5'b00010, 0, 1, 2'b00, 32'h0, 32'h100, 32'hCAFE, 16'h0008, 5'd1, 5'd9, 32'h108, 0, 5'd1, 32'h20);
    op1("and",     5'b10000, 1, 0, 2'b10, 32'h0, 32'hF0F0, 32'hFF00, 16'h0024, 5'd1, 5'd10, 32'hF000, 0, 5'd10, 32'h90);
    op1("or",      5'b10000, 1, 0, 2'b10, 32'h0, 32'hF0F0, 32'hFF00, 16'h0025, 5'd1, 5'd10, 32'hFFF0, 0, 5'd10, 32'h94);
    op1("sub",     5'b10000, 1, 0, 2'b10, 32'h0, 32'd3, 32'd5, 16'h0022, 5'd1, 5'd11, 32'hFFFFFFFE, 0, 5'd11, 32'h88);
    op1("bad_fn",  5'b10000, 1, 0, 2'b10, 32'h0, 32'd5, 32'd7, 16'h003F, 5'd1, 5'd12, 32'd0, 1, 5'd12, 32'hFC);
    op1("op11",    5'b10000, 0, 0, 2'b11, 32'h8, 32'hFFFFFFFF, 32'd1, 16'h0000, 5'd13, 5'd1, 32'd0, 1, 5'd13, 32'h8);

    mul("mul_7x6", 32'd7, 32'd6, 32'd42);
    mul("mul_big", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);

    // Abort a multiply in its tenth MUL_RUN cycle
    k = cyc;
    setin(5'b10000, 1'b1, 1'b0, 2'b10, 32'h200, 32'd3, 32'd5, 16'h0018, 5'd4, 5'd5);
    for (int c = k; c <= k + 9; c++) begin
      chk(c, 0, 32'd1, "abort_busy");
      if (c > k) chk(c, 1, 32'd0, "abort_bubble");
    end
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    chk(cyc, 0, 32'd0, "abort_rst_busy");
    expout(cyc, 5'b00000, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, "abort_rst_out");
    @(posedge clk); #1;
    expout(cyc, 5'b00000, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, "abort_held");
    reset = 1'b0;
    op1("post_rst", 5'b10000, 1, 0, 2'b00, 32'h4, 32'd1, 32'd1, 16'h0000, 5'd0, 5'd2, 32'd2, 0, 5'd2, 32'h4);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_bad += q.size();
      $display("FAIL leftover_expectations got=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports (clock and reset first):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- wb_RegWrite, wb_MemToReg, mem_MemRead, mem_MemWrite  in  1 each  control fields from the ID/EX register
- ex_RegDst, ex_AluSrc, ex_branch  in  1 each  EX control fields from the ID/EX register
- ex_AluOp  in  2  ALU operation class
- pc4, read_data1, read_data2  in  32 each  PC+4 and register operands
- immediate  in  16  raw immediate; [5:0] is funct
- rt, rd  in  5 each  destination candidates
- wb_RegWrite_out, wb_MemToReg_out, mem_MemRead_out, mem_MemWrite_out, mem_branch_out  out  1 each  EX/MEM control
- branch_target_out  out  32  pc4 + (sign-extended immediate << 2)
- zero_out  out  1  ALU result == 0
- alu_result_out  out  32  ALU or multiply result
- write_data_out  out  32  read_data2 passed through for stores
- dest_reg_out  out  5  rd if ex_RegDst, else rt
- ex_busy  out  1  stall request to PC, IF/ID and ID/EX
REQ-002 SHALL use reset: asynchronous, active-high; clock: clk.
REQ-003 SHALL register every *_out on clk rising edge (EX/MEM register inside this block); ex_busy SHALL be combinational.

Function
REQ-004 ALU operand B SHALL be sign-extended immediate when ex_AluSrc=1, else read_data2.
REQ-005 ex_AluOp 00 -> add; 01 -> subtract; 11 -> add; 10 -> decode funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (result 1/0), 0x18 mult; any other funct -> result 0.
REQ-006 add/sub SHALL wrap modulo 2^32; no overflow detection.
REQ-007 mult SHALL produce the low 32 bits of the unsigned 32x32 product using an iterative shift-add unit, one multiplier bit per cycle.
REQ-008 Single-cycle ops SHALL be visible on the outputs one edge after presentation (latency 1).
REQ-009 FSM states SHALL be IDLE, MUL_RUN, MUL_DONE.
REQ-010 IDLE + mult presented -> ex_busy=1 that cycle; next edge: load operands, clear 5-bit counter, go to MUL_RUN; EX/MEM loads a bubble.
REQ-011 MUL_RUN: ex_busy=1; one iteration per edge; after the 32nd iteration go to MUL_DONE; EX/MEM loads a bubble each edge.
REQ-012 MUL_DONE: ex_busy=0; the edge loads product plus the held control fields into EX/MEM; go to IDLE.
REQ-013 Total: ex_busy high for exactly 33 cycles; product on alu_result_out after the 34th edge.
REQ-014 Bubble SHALL mean all five control outputs 0; data outputs don't-care but SHALL hold previous values.
REQ-015 Upstream SHALL hold ID/EX inputs stable while ex_busy=1; the block SHALL sample pc4, rt, rd, controls and read_data2 in MUL_DONE from the inputs.
REQ-016 Back-to-back mults SHALL each take the full sequence; MUL_DONE SHALL NOT re-trigger on the same instruction.
REQ-017 branch_target_out and zero_out SHALL be computed for every op; mem_branch_out SHALL equal ex_branch.

Reset
REQ-018 reset SHALL force all *_out to 0, FSM to IDLE, counter to 0, ex_busy to 0, immediately and asynchronously.
REQ-019 reset during MUL_RUN/MUL_DONE SHALL abort the multiply; no partial product SHALL reach the outputs.
REQ-020 mem_branch_out SHALL be 0 from reset until the first valid instruction reaches it, so the PC increments normally.

Structure
REQ-021 Package ex_pkg SHALL hold AluOp encodings, funct constants, and the FSM state type.
REQ-022 The iterative multiplier SHALL be sub-module ex_mul_iter (start, operands, done, product); ALU decode, FSM and EX/MEM register stay in ex_stage.

Verification
REQ-023 AluOp=10, funct 0x20, rd1=5, rd2=7, RegDst=1, rd=3 -> next edge alu_result_out=12, dest_reg_out=3, zero_out=0.
REQ-024 AluOp=01, rd1=rd2=0x1234, branch=1, pc4=0x100, imm=0xFFFF -> zero_out=1, mem_branch_out=1, branch_target_out=0xFC.
REQ-025 AluOp=10, funct 0x2A, rd1=0xFFFFFFFF, rd2=1 -> alu_result_out=1; swap operands -> 0.
REQ-026 mult 7*6 -> ex_busy high 33 cycles, bubbles meanwhile, alu_result_out=42 after edge 34; 0xFFFFFFFF*2 -> 0xFFFFFFFE.
REQ-027 reset asserted in MUL_RUN cycle 10 -> outputs 0, ex_busy 0 immediately; after release, add 1+1 -> 2 at latency 1.
